// File: rtl/if_id_queue.sv
// ============================================================================
// if_id_queue -- DEPTH-entry in-order fetch queue between IF and ID.
//
// Holds {instruction, PC+4} pairs pushed on instruction-memory hits and
// popped when ID advances, decoupling fetch from decode stalls. A flush
// discards every entry on a branch/jump mispredict. ID sees a NOP bubble
// while the queue is empty.
//
// Parameters:
//   WIDTH  bit width of the instruction and PC+4 words
//   DEPTH  number of entries (power of two, >= 2)
//   NOP    instruction presented while the queue is empty
//
// Ports:
//   CLK        system clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   imemload   fetched instruction
//   pcp4       PC+4 of the fetched instruction
//   iHit       push request (imemload/pcp4 valid this cycle)
//   flush      discard all entries
//   enable     pop request (ID consumes the head this cycle)
//   instr      head instruction, NOP when empty
//   pcp4_out   head PC+4, 0 when empty
//   valid      queue non-empty
//   full       count == DEPTH, IF must stall
//   count      occupancy 0..DEPTH
//   ovf        sticky: a push was dropped while full (cleared by flush/reset)
//
// Optional feature (macro IF_ID_QUEUE_STATS_EN):
//   flush_drops  saturating sum of entries discarded by flushes
//   full_cycles  saturating count of cycles with full=1 and iHit=1
// ============================================================================
module if_id_queue #(
    parameter int unsigned      WIDTH = 32,
    parameter int unsigned      DEPTH = 4,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h0000_0000)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             imemload,
    input  logic [WIDTH-1:0]             pcp4,
    input  logic                         iHit,
    input  logic                         flush,
    input  logic                         enable,
    output logic [WIDTH-1:0]             instr,
    output logic [WIDTH-1:0]             pcp4_out,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef IF_ID_QUEUE_STATS_EN
    output logic [15:0]                  flush_drops,
    output logic [15:0]                  full_cycles,
`endif
    output logic                         ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    // One queue slot: instruction plus its PC+4.
    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pcp4;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Flags are decoded from the occupancy counter.
    assign valid = (count != CNT_W'(0));
    assign full  = (count == CNT_W'(DEPTH));

    // A push into a full queue is legal only when the head leaves in the
    // same cycle; flush wins over both requests.
    assign pop  = enable & valid;
    assign push = iHit & ~flush & (~full | pop);

    // Head is read straight out of storage, no output register stage.
    assign instr    = valid ? mem[rd_ptr].instr : NOP;
    assign pcp4_out = valid ? mem[rd_ptr].pcp4  : WIDTH'(0);

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem[wr_ptr] <= '{instr: imemload, pcp4: pcp4};
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (iHit && full && !pop) ovf <= 1'b1;
        end
    end

`ifdef IF_ID_QUEUE_STATS_EN
    logic [16:0] drops_sum;

    assign drops_sum = {1'b0, flush_drops} + 17'(count);

    // Saturating statistics; survive flushes, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flush_drops <= '0;
            full_cycles <= '0;
        end else begin
            if (flush) begin
                flush_drops <= drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
            end
            if (full && iHit && (full_cycles != 16'hFFFF)) begin
                full_cycles <= full_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry in-order fetch queue between IF and ID.
- Each entry holds an {instruction, PC+4} pair. Entries are pushed on instruction-memory hits and popped when ID advances.
- Decouples fetch from decode stalls.
- Supports full flush on branch/jump mispredict. Presents a NOP bubble to ID when empty.

Parameters:
- WIDTH, 32, bit width of instruction and PC+4 words (word_t).
- DEPTH, 4, number of queue entries; power of two, >= 2.
- NOP, 32'h0000_0000, value driven on instr while the queue is empty.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- imemload  input  WIDTH  instruction fetched from imem.
- pcp4  input  WIDTH  PC+4 of the fetched instruction.
- iHit  input  1  push request; imemload/pcp4 valid this cycle.
- flush  input  1  discard all entries (mispredict/jump).
- enable  input  1  pop request; ID consumes the head entry this cycle.
- instr  output  WIDTH  head instruction, or NOP when empty.
- pcp4_out  output  WIDTH  head PC+4, or 0 when empty.
- valid  output  1  queue non-empty (head entry meaningful).
- full  output  1  count == DEPTH; IF must stall the PC.
- count  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH.
- ovf  output  1  sticky error: a push was dropped while full.

Behaviour:
- Storage:
  - Circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count register.
  - Outputs are a combinational read of entry[rd_ptr]; no extra register stage.
- Reset (RST=1 at edge): wr_ptr=0, rd_ptr=0, count=0, ovf=0.
  - Results in instr=NOP, pcp4_out=0, valid=0, full=0.
  - Storage contents are don't-care.
  - RST overrides flush, push and pop in the same cycle.
- Qualifiers:
  - push = iHit & ~flush & (~full | pop).
  - pop = enable & valid.
- Latency: an entry pushed at edge N appears at the head at N+1 if the queue was empty. There is no same-cycle bypass.
- Push: entry[wr_ptr] <= {imemload, pcp4}; wr_ptr++.
- Pop: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push+pop when full: allowed. count stays DEPTH; both pointers advance.
- Simultaneous push+pop when empty: the pop is ignored (valid=0). Push proceeds; count becomes 1.
- Push while full without pop: entry dropped, state unchanged, ovf <= 1.
- Pop while empty: ignored. Outputs remain NOP/0, with no pointer movement.
- Flush (RST=0, flush=1): wr_ptr=0, rd_ptr=0, count=0 at the edge.
  - Any same-cycle iHit and enable are discarded.
  - ovf is cleared.
  - The next cycle shows instr=NOP, valid=0.
- Pointer wrap: pointers roll from DEPTH-1 to 0 with no discontinuity in FIFO order.
- Flags: full and valid are decoded from count, not stored separately.

Optional Feature:
- Macro IF_ID_QUEUE_STATS_EN.
- When defined:
  - Adds outputs flush_drops[15:0] and full_cycles[15:0]. Both reset to 0 on RST.
  - Both are saturating at 16'hFFFF and are not cleared by flush.
  - flush_drops += count on each flush edge.
  - full_cycles += 1 for each cycle with full=1 and iHit=1.
- When undefined: the ports and logic are absent; the interface is as listed above.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then iHit=enable=0 -> instr=0, pcp4_out=0, valid=0, full=0, count=0, ovf=0.
- Fill/drain, DEPTH=4:
  - Push 0xA0..0xA3 with pcp4 0x4..0x10 -> full=1 and count=4 after 4 edges.
  - Then enable=1 for 4 cycles -> instr reads A0, A1, A2, A3 in order; then valid=0 and instr=NOP.
- Full with push+pop:
  - At count=4, iHit=1 (0xB0) and enable=1 -> head advances to the next entry, count stays 4, 0xB0 emerges after 3 more pops.
  - ovf stays 0 throughout.
- Overflow: at count=4, iHit=1 (0xC0) with enable=0 -> count=4, ovf=1, 0xC0 never appears at the head.
- Flush priority: at count=3, flush=1 with iHit=1 (0xD0) and enable=1 -> next cycle count=0, valid=0, ovf=0; 0xD0 is not stored.
- Wrap and stats:
  - 10 push/pop pairs -> order preserved across pointer wrap.
  - With IF_ID_QUEUE_STATS_EN, flush at count=2 -> flush_drops=2.
